vector_mac_stream: RTL and testbench
====================================

Name: vector_mac_stream

Overview:
- Streaming, folded successor to the single-cycle dot-product unit used in the linear-layer datapath.
- Accepts a vector of LANES*NUM_BEATS feature/weight pairs, LANES pairs per beat, over a valid/ready handshake.
- Accumulates the dot product (acc) and the feature sum (ai, used downstream for zero-point correction), then presents both on a held output handshake.
- Supports signed or unsigned operands via a parameter.

Parameters:
- PRECISION, 8: width of each feature and weight element.
- LANES, 4: element pairs consumed per accepted beat.
- NUM_BEATS, 4: beats per vector (≥1); vector length = LANES*NUM_BEATS.
- ACC_WIDTH, 32: width of the acc and ai outputs and internal accumulators.
- SIGNED, 1: 1 = two's-complement operands, 0 = unsigned operands.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  block can accept a beat
- features_in  in  [PRECISION-1:0] x LANES  feature elements of the beat
- weights_in  in  [PRECISION-1:0] x LANES  weight elements of the beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- acc  out  ACC_WIDTH  dot product of completed vector
- ai  out  ACC_WIDTH  sum of features of completed vector
- sat  out  1  saturation occurred (present only with VECMAC_SATURATE_EN)

Behaviour:
- Reset (synchronous) values: acc=0, ai=0, out_valid=0, beat counter=0, state=ACCUM, sat=0.
- in_ready = (state==ACCUM) && !rst.
- States:
  - ACCUM: a beat is accepted when in_valid && in_ready. On acceptance: acc_r += Σ features_in[i]*weights_in[i]; ai_r += Σ features_in[i]; beat counter +1.
  - ACCUM → HOLD: on acceptance of beat NUM_BEATS-1. The counter wraps to 0.
  - HOLD: out_valid=1; acc and ai are stable, and in_ready=0 so no beats are accepted. On out_valid && out_ready: acc_r and ai_r clear to 0, out_valid=0 next cycle, return to ACCUM.
- Latency: out_valid asserts the cycle after the last beat is accepted.
- Throughput: one vector per NUM_BEATS+1 cycles with out_ready held high and no input bubbles.
- Input bubbles (in_valid=0) in ACCUM: no state or accumulator change.
- Arithmetic:
  - Each product and each feature is sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH before summation.
  - All sums wrap modulo 2^ACC_WIDTH.
  - The per-beat sum and the accumulate form a single combinational path into the register, with no intermediate pipeline.
- Features/weights present while in_ready=0 are ignored.
- rst mid-vector or mid-HOLD discards the partial or held result; the next accepted beat starts a fresh vector.
- NUM_BEATS=1: every accepted beat produces a result.

Optional Feature:
- Macro: VECMAC_SATURATE_EN.
- Defined:
  - Each accumulate of acc_r clamps to the representable range: [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] when SIGNED=1, [0, 2^ACC_WIDTH-1] when SIGNED=0.
  - Port sat exists and is set sticky when any clamp occurs within the vector. It is valid with out_valid and cleared on output handshake or rst.
  - ai is never saturated.
- Not defined: acc wraps, and no sat port exists.

Test Plan:
- Common config unless noted: LANES=4, NUM_BEATS=2, PRECISION=8, ACC_WIDTH=32, SIGNED=1.
- Basic: features 1..8 over two beats, weights all 2, out_ready=1 → out_valid one cycle after beat 2; acc=72, ai=36; in_ready=0 for exactly that cycle.
- Signed extremes: all features 0x80, all weights 0x80 → acc=131072, ai=0xFFFFFC00 (-1024). With SIGNED=0 and the same inputs → acc=131072, ai=1024.
- Backpressure: out_ready=0 for 5 cycles after completion → out_valid, acc and ai held stable, in_ready=0, and beats driven meanwhile leave the next result unchanged.
- Bubbles and reset: insert 3 idle cycles between beats → same result as Basic. Assert rst for 1 cycle after beat 1, then send the Basic vector → acc=72, ai=36 (the partial beat is discarded).
- Saturation (ACC_WIDTH=16): all features 127, all weights 127 → with macro: acc=0x7FFF, sat=1, ai=1016; without macro: acc=0xF808, ai=1016.

Source files
------------

// File: rtl/vector_mac_stream.sv
// Streaming folded dot-product: accumulates LANES pairs per beat over NUM_BEATS beats, then holds acc/ai.
// Optional clamping of acc (and sticky sat port) when VECMAC_SATURATE_EN is defined.
module vector_mac_stream #(
    parameter int unsigned PRECISION = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned NUM_BEATS = 4,
    parameter int unsigned ACC_WIDTH = 32,
    parameter bit          SIGNED    = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [LANES-1:0][PRECISION-1:0]     features_in,
    input  logic [LANES-1:0][PRECISION-1:0]     weights_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ACC_WIDTH-1:0]                acc,
    output logic [ACC_WIDTH-1:0]                ai
`ifdef VECMAC_SATURATE_EN
    ,
    output logic                                sat
`endif
);

    localparam int unsigned CNT_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int unsigned PROD_W = 2 * PRECISION + 2;
    localparam int unsigned BASE_W = (ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W;
    // Headroom so a full beat plus the running acc never wraps before clamping.
    localparam int unsigned EXT_W  = BASE_W + $clog2(LANES + 1) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [ACC_WIDTH-1:0]    ai_q, ai_d;
    logic                    beat_fire;
    logic signed [EXT_W-1:0] prod_sum, feat_sum, acc_ext, acc_sum;
    logic [ACC_WIDTH-1:0]    acc_next;
    logic                    unused_hi;

    assign in_ready  = (state_q == ST_ACCUM) && !rst;
    assign beat_fire = in_valid && in_ready;

    always_comb begin : beat_sum
        logic signed [PRECISION:0]  f_x;
        logic signed [PRECISION:0]  w_x;
        logic signed [PROD_W-1:0]   p;
        f_x      = '0;
        w_x      = '0;
        p        = '0;
        prod_sum = '0;
        feat_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            f_x      = {SIGNED & features_in[i][PRECISION-1], features_in[i]};
            w_x      = {SIGNED & weights_in[i][PRECISION-1], weights_in[i]};
            p        = PROD_W'(f_x) * PROD_W'(w_x);
            prod_sum = prod_sum + EXT_W'(p);
            feat_sum = feat_sum + EXT_W'(f_x);
        end
    end

    assign acc_ext   = SIGNED ? EXT_W'($signed(acc_q)) : $signed(EXT_W'(acc_q));
    assign acc_sum   = acc_ext + prod_sum;
    assign unused_hi = ^{acc_sum[EXT_W-1:ACC_WIDTH], feat_sum[EXT_W-1:ACC_WIDTH]};

`ifdef VECMAC_SATURATE_EN
    logic sat_q, sat_d;
    logic clamp;

    always_comb begin
        clamp    = 1'b0;
        acc_next = acc_sum[ACC_WIDTH-1:0];
        if (SIGNED) begin
            if (acc_sum[EXT_W-1:ACC_WIDTH-1] != {(EXT_W-ACC_WIDTH+1){acc_sum[EXT_W-1]}}) begin
                clamp    = 1'b1;
                acc_next = acc_sum[EXT_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                            : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else if (acc_sum[EXT_W-1:ACC_WIDTH] != '0) begin
            clamp    = 1'b1;
            acc_next = '1;
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (state_q == ST_ACCUM) begin
            if (beat_fire) sat_d = sat_q | clamp;
        end else if (out_ready) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sat_q <= 1'b0;
        else     sat_q <= sat_d;
    end

    assign sat = sat_q;
`else
    assign acc_next = acc_sum[ACC_WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ai_d    = ai_q;
        if (state_q == ST_ACCUM) begin
            if (beat_fire) begin
                acc_d = acc_next;
                ai_d  = ai_q + feat_sum[ACC_WIDTH-1:0];
                if (cnt_q == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (out_ready) begin
            acc_d   = '0;
            ai_d    = '0;
            state_d = ST_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            ai_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ai_q    <= ai_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign acc       = acc_q;
    assign ai        = ai_q;

endmodule

// File: tb/tb_vector_mac_stream.sv
// Directed bench for vector_mac_stream: three instances (signed/32, unsigned/32, signed/16) share one stimulus.
// Expectations for acc of the 16-bit instance depend on VECMAC_SATURATE_EN.
module tb_vector_mac_stream;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             out_ready;
    logic [3:0][7:0]  features_in;
    logic [3:0][7:0]  weights_in;

    logic             in_ready_m, out_valid_m;
    logic [31:0]      acc_m, ai_m;
    logic             in_ready_u, out_valid_u;
    logic [31:0]      acc_u, ai_u;
    logic             in_ready_s, out_valid_s;
    logic [15:0]      acc_s, ai_s;
`ifdef VECMAC_SATURATE_EN
    logic             sat_m, sat_u, sat_s;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] B1   = 32'h04030201;
    localparam logic [31:0] B2   = 32'h08070605;
    localparam logic [31:0] W2   = 32'h02020202;
    localparam logic [31:0] X80  = 32'h80808080;
    localparam logic [31:0] X7F  = 32'h7F7F7F7F;
    localparam logic [31:0] JUNK = 32'hFFFFFFFF;

    always #5 clk = ~clk;

    vector_mac_stream #(.PRECISION(8), .LANES(4), .NUM_BEATS(2), .ACC_WIDTH(32), .SIGNED(1'b1)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .features_in(features_in), .weights_in(weights_in),
        .out_valid(out_valid_m), .out_ready(out_ready), .acc(acc_m), .ai(ai_m)
`ifdef VECMAC_SATURATE_EN
        , .sat(sat_m)
`endif
    );

    vector_mac_stream #(.PRECISION(8), .LANES(4), .NUM_BEATS(2), .ACC_WIDTH(32), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .features_in(features_in), .weights_in(weights_in),
        .out_valid(out_valid_u), .out_ready(out_ready), .acc(acc_u), .ai(ai_u)
`ifdef VECMAC_SATURATE_EN
        , .sat(sat_u)
`endif
    );

    vector_mac_stream #(.PRECISION(8), .LANES(4), .NUM_BEATS(2), .ACC_WIDTH(16), .SIGNED(1'b1)) u_a16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .features_in(features_in), .weights_in(weights_in),
        .out_valid(out_valid_s), .out_ready(out_ready), .acc(acc_s), .ai(ai_s)
`ifdef VECMAC_SATURATE_EN
        , .sat(sat_s)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] f, input logic [31:0] w);
        in_valid    = v;
        features_in = f;
        weights_in  = w;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, '0);
        tick();
        tick();

        // reset state
        check("rst_in_ready", 32'(in_ready_m), 32'd0);
        check("rst_out_valid", 32'(out_valid_m), 32'd0);
        check("rst_acc", acc_m, 32'd0);
        check("rst_ai", ai_m, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready_m), 32'd1);

        // basic vector: 1..8 times 2
        drive(1'b1, B1, W2);
        tick();
        check("basic_mid_in_ready", 32'(in_ready_m), 32'd1);
        check("basic_mid_out_valid", 32'(out_valid_m), 32'd0);
        drive(1'b1, B2, W2);
        tick();
        drive(1'b0, '0, '0);
        check("basic_out_valid", 32'(out_valid_m), 32'd1);
        check("basic_in_ready", 32'(in_ready_m), 32'd0);
        check("basic_acc", acc_m, 32'd72);
        check("basic_ai", ai_m, 32'd36);
        check("basic_uns_acc", acc_u, 32'd72);
        check("basic_a16_in_ready", 32'(in_ready_s), 32'd0);
        check("basic_uns_in_ready", 32'(in_ready_u), 32'd0);
`ifdef VECMAC_SATURATE_EN
        check("basic_sat", 32'(sat_m), 32'd0);
`endif
        tick();
        check("basic_after_out_valid", 32'(out_valid_m), 32'd0);
        check("basic_after_in_ready", 32'(in_ready_m), 32'd1);
        check("basic_after_acc", acc_m, 32'd0);
        check("basic_after_ai", ai_m, 32'd0);

        // signed / unsigned extremes
        drive(1'b1, X80, X80);
        tick();
        tick();
        drive(1'b0, '0, '0);
        check("ext_out_valid", 32'(out_valid_m), 32'd1);
        check("ext_acc", acc_m, 32'h0002_0000);
        check("ext_ai", ai_m, 32'hFFFF_FC00);
        check("ext_uns_out_valid", 32'(out_valid_u), 32'd1);
        check("ext_uns_acc", acc_u, 32'h0002_0000);
        check("ext_uns_ai", ai_u, 32'd1024);
        tick();

        // backpressure with junk beats offered during hold
        out_ready = 1'b0;
        drive(1'b1, B1, W2);
        tick();
        drive(1'b1, B2, W2);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, JUNK, X7F);
            check("bp_out_valid", 32'(out_valid_m), 32'd1);
            check("bp_in_ready", 32'(in_ready_m), 32'd0);
            check("bp_acc", acc_m, 32'd72);
            check("bp_ai", ai_m, 32'd36);
            tick();
        end
        drive(1'b0, '0, '0);
        check("bp_end_out_valid", 32'(out_valid_m), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 32'(out_valid_m), 32'd0);
        drive(1'b1, B1, W2);
        tick();
        drive(1'b1, B2, W2);
        tick();
        drive(1'b0, '0, '0);
        check("bp_next_acc", acc_m, 32'd72);
        check("bp_next_ai", ai_m, 32'd36);
        tick();

        // input bubbles between beats
        drive(1'b1, B1, W2);
        tick();
        drive(1'b0, JUNK, JUNK);
        for (int i = 0; i < 3; i++) begin
            check("bubble_out_valid", 32'(out_valid_m), 32'd0);
            tick();
        end
        drive(1'b1, B2, W2);
        tick();
        drive(1'b0, '0, '0);
        check("bubble_out_valid_done", 32'(out_valid_m), 32'd1);
        check("bubble_acc", acc_m, 32'd72);
        check("bubble_ai", ai_m, 32'd36);
        tick();

        // reset mid-vector
        drive(1'b1, B1, W2);
        tick();
        drive(1'b0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_acc", acc_m, 32'd0);
        check("rstmid_ai", ai_m, 32'd0);
        drive(1'b1, B1, W2);
        tick();
        drive(1'b1, B2, W2);
        tick();
        drive(1'b0, '0, '0);
        check("rstmid_out_valid", 32'(out_valid_m), 32'd1);
        check("rstmid_acc_final", acc_m, 32'd72);
        check("rstmid_ai_final", ai_m, 32'd36);
        tick();

        // reset during hold
        out_ready = 1'b0;
        drive(1'b1, B1, W2);
        tick();
        drive(1'b1, B2, W2);
        tick();
        drive(1'b0, '0, '0);
        check("rsthold_pre_out_valid", 32'(out_valid_m), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsthold_out_valid", 32'(out_valid_m), 32'd0);
        check("rsthold_acc", acc_m, 32'd0);
        check("rsthold_ai", ai_m, 32'd0);
        out_ready = 1'b1;

        // saturation / wrap on the 16-bit instance
        drive(1'b1, X7F, X7F);
        tick();
        tick();
        drive(1'b0, '0, '0);
        check("sat_out_valid", 32'(out_valid_s), 32'd1);
        check("sat_ai", 32'(ai_s), 32'd1016);
        check("sat_main_acc", acc_m, 32'h0001_F808);
`ifdef VECMAC_SATURATE_EN
        check("sat_acc", 32'(acc_s), 32'h0000_7FFF);
        check("sat_flag", 32'(sat_s), 32'd1);
        check("sat_main_flag", 32'(sat_m), 32'd0);
`else
        check("wrap_acc", 32'(acc_s), 32'h0000_F808);
`endif
        tick();
        check("sat_after_out_valid", 32'(out_valid_s), 32'd0);
`ifdef VECMAC_SATURATE_EN
        check("sat_after_flag", 32'(sat_s), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
